// File: rtl/micro_sequencer.sv
// Microprogram sequencer: walks a block of consecutive microcode ROM words and
// presents each registered word with its data address to the decode stage.
module micro_sequencer #(
    parameter int ROM_AW = 7,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROM_AW-1:0] start_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic [10:0]       data_base,
    input  logic              stall,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [32:0]       rom_data,
    output logic [32:0]       micro_instr_out,
    output logic [10:0]       data_address_out,
    output logic              instr_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q,       state_d;
    logic [ROM_AW-1:0] rom_addr_q,    rom_addr_d;
    logic [CNT_W-1:0]  remaining_q,   remaining_d;
    logic [CNT_W-1:0]  idx_q,         idx_d;
    logic [10:0]       base_q,        base_d;
    logic [32:0]       instr_q,       instr_d;
    logic [10:0]       data_addr_q,   data_addr_d;
    logic              valid_q,       valid_d;
    logic              busy_q,        busy_d;
    logic              done_q,        done_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; a missing default here would infer a latch.
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        base_d      = base_q;
        instr_d     = instr_q;
        data_addr_d = data_addr_q;
        valid_d     = valid_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        rom_addr_d  = start_addr;
                        remaining_d = count;
                        idx_d       = '0;
                        base_d      = data_base;
                        state_d     = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            // Under stall the ROM address is not advanced, so rom_data keeps the
            // pending word and is captured intact once stall drops.
            S_RUN: begin
                if (!stall) begin
                    instr_d     = rom_data;
                    data_addr_d = base_q + 11'(idx_q);
                    valid_d     = 1'b1;
                    rom_addr_d  = rom_addr_q + ROM_AW'(1);
                    idx_d       = idx_q + CNT_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (!stall) begin
                    instr_d = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            instr_q     <= '0;
            data_addr_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, regardless of statement order.
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            instr_q     <= instr_d;
            data_addr_q <= data_addr_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rom_addr         = rom_addr_q;
    assign micro_instr_out  = instr_q;
    assign data_address_out = data_addr_q;
    assign instr_valid      = valid_q;
    assign busy             = busy_q;
    assign done             = done_q;

    done_valid_exclusive: assert property (
        @(posedge clk) disable iff (reset) !(done_q && valid_q)
    );

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a combinational ROM model driven by
// the registered rom_addr.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  start_addr;
    logic [7:0]  count;
    logic [10:0] data_base;
    logic        stall;
    logic [6:0]  rom_addr;
    logic [32:0] rom_data;
    logic [32:0] micro_instr_out;
    logic [10:0] data_address_out;
    logic        instr_valid;
    logic        busy;
    logic        done;

    int total  = 0;
    int passed = 0;

    micro_sequencer #(.ROM_AW(7), .CNT_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .data_base        (data_base),
        .stall            (stall),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .micro_instr_out  (micro_instr_out),
        .data_address_out (data_address_out),
        .instr_valid      (instr_valid),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] rom_word(input logic [6:0] a);
        return {a[0], 16'hBEEF, 9'h0A5 ^ {2'b00, a}, a};
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic launch(input logic [6:0] sa, input logic [7:0] cnt, input logic [10:0] db);
        start      = 1'b1;
        start_addr = sa;
        count      = cnt;
        data_base  = db;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        logic [53:0] all_out;
        all_out = {rom_addr, micro_instr_out, data_address_out, instr_valid, busy, done};
        total++;
        if (all_out !== 54'h0) $display("FAIL reset_initial: got %h want 0", all_out);
        else passed++;
        @(negedge clk);
        reset = 1'b0;

        launch(7'h20, 8'd5, 11'h040);
        tick();
        tick();
        total++;
        if ({busy, instr_valid} !== 2'b11) $display("FAIL reset_prerun: got %b want 11", {busy, instr_valid});
        else passed++;
        #2 reset = 1'b1;
        #1;
        all_out = {rom_addr, micro_instr_out, data_address_out, instr_valid, busy, done};
        total++;
        if (all_out !== 54'h0) $display("FAIL reset_async: got %h want 0", all_out);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({done, busy, instr_valid} !== 3'b000)
                $display("FAIL reset_after[%0d]: got %b want 000", k, {done, busy, instr_valid});
            else passed++;
        end
    endtask

    task automatic test_basic;
        logic [44:0] exp_w;
        launch(7'h10, 8'd3, 11'h100);
        total++;
        if ({busy, instr_valid, done} !== 3'b100) $display("FAIL basic_e0: got %b want 100", {busy, instr_valid, done});
        else passed++;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_w = {1'b1, rom_word(7'(7'h10 + k)), 11'(11'h100 + k)};
            total++;
            if ({instr_valid, micro_instr_out, data_address_out} !== exp_w)
                $display("FAIL basic_word[%0d]: got %h want %h", k, {instr_valid, micro_instr_out, data_address_out}, exp_w);
            else passed++;
        end
        tick();
        total++;
        if ({done, busy, instr_valid, micro_instr_out} !== {3'b100, 33'h0})
            $display("FAIL basic_done: got %h want %h", {done, busy, instr_valid, micro_instr_out}, {3'b100, 33'h0});
        else passed++;
        tick();
        total++;
        if ({done, busy} !== 2'b00) $display("FAIL basic_idle: got %b want 00", {done, busy});
        else passed++;
    endtask

    task automatic test_stall;
        logic [51:0] exp_h;
        logic [44:0] exp_w;
        launch(7'h10, 8'd3, 11'h100);
        tick();
        exp_h = {1'b1, rom_word(7'h10), 11'h100, 7'h11};
        total++;
        if ({instr_valid, micro_instr_out, data_address_out, rom_addr} !== exp_h)
            $display("FAIL stall_first: got %h want %h", {instr_valid, micro_instr_out, data_address_out, rom_addr}, exp_h);
        else passed++;
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if ({instr_valid, micro_instr_out, data_address_out, rom_addr} !== exp_h)
                $display("FAIL stall_hold[%0d]: got %h want %h", k, {instr_valid, micro_instr_out, data_address_out, rom_addr}, exp_h);
            else passed++;
        end
        stall = 1'b0;
        for (int k = 1; k < 3; k++) begin
            tick();
            exp_w = {1'b1, rom_word(7'(7'h10 + k)), 11'(11'h100 + k)};
            total++;
            if ({instr_valid, micro_instr_out, data_address_out} !== exp_w)
                $display("FAIL stall_word[%0d]: got %h want %h", k, {instr_valid, micro_instr_out, data_address_out}, exp_w);
            else passed++;
        end
        stall = 1'b1;
        tick();
        total++;
        if ({done, busy, instr_valid, micro_instr_out} !== {3'b011, rom_word(7'h12)})
            $display("FAIL stall_done_hold: got %h want %h", {done, busy, instr_valid, micro_instr_out}, {3'b011, rom_word(7'h12)});
        else passed++;
        stall = 1'b0;
        tick();
        total++;
        if ({done, busy, instr_valid, micro_instr_out} !== {3'b100, 33'h0})
            $display("FAIL stall_done: got %h want %h", {done, busy, instr_valid, micro_instr_out}, {3'b100, 33'h0});
        else passed++;
        tick();
    endtask

    task automatic test_wrap;
        logic [51:0] exp_r;
        launch(7'h7E, 8'd4, 11'h7FE);
        total++;
        if (rom_addr !== 7'h7E) $display("FAIL wrap_addr0: got %h want 7e", rom_addr);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_r = {1'b1, rom_word(7'(7'h7E + k)), 11'(11'h7FE + k), 7'(7'h7E + k + 1)};
            total++;
            if ({instr_valid, micro_instr_out, data_address_out, rom_addr} !== exp_r)
                $display("FAIL wrap_word[%0d]: got %h want %h", k, {instr_valid, micro_instr_out, data_address_out, rom_addr}, exp_r);
            else passed++;
        end
        tick();
        total++;
        if ({done, busy, instr_valid} !== 3'b100) $display("FAIL wrap_done: got %b want 100", {done, busy, instr_valid});
        else passed++;
        tick();
    endtask

    task automatic test_zero_count;
        launch(7'h05, 8'd0, 11'h123);
        total++;
        if ({busy, instr_valid, done} !== 3'b100) $display("FAIL zero_e0: got %b want 100", {busy, instr_valid, done});
        else passed++;
        tick();
        total++;
        if ({done, busy, instr_valid} !== 3'b100) $display("FAIL zero_done: got %b want 100", {done, busy, instr_valid});
        else passed++;
        tick();
        total++;
        if ({done, busy, instr_valid} !== 3'b000) $display("FAIL zero_idle: got %b want 000", {done, busy, instr_valid});
        else passed++;
    endtask

    task automatic test_ignored_start;
        logic [44:0] exp_w;
        launch(7'h30, 8'd3, 11'h200);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                start      = 1'b1;
                start_addr = 7'h50;
                count      = 8'd7;
                data_base  = 11'h003;
            end
            tick();
            start = 1'b0;
            exp_w = {1'b1, rom_word(7'(7'h30 + k)), 11'(11'h200 + k)};
            total++;
            if ({instr_valid, micro_instr_out, data_address_out} !== exp_w)
                $display("FAIL ignore_word[%0d]: got %h want %h", k, {instr_valid, micro_instr_out, data_address_out}, exp_w);
            else passed++;
        end
        tick();
        total++;
        if ({done, busy, instr_valid} !== 3'b100) $display("FAIL ignore_done: got %b want 100", {done, busy, instr_valid});
        else passed++;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if ({done, busy, instr_valid} !== 3'b000)
                $display("FAIL ignore_idle[%0d]: got %b want 000", k, {done, busy, instr_valid});
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [44:0] exp_w;
        launch(7'h40, 8'd1, 11'h010);
        tick();
        exp_w = {1'b1, rom_word(7'h40), 11'h010};
        total++;
        if ({instr_valid, micro_instr_out, data_address_out} !== exp_w)
            $display("FAIL b2b_single: got %h want %h", {instr_valid, micro_instr_out, data_address_out}, exp_w);
        else passed++;
        tick();
        total++;
        if ({done, busy} !== 2'b10) $display("FAIL b2b_done: got %b want 10", {done, busy});
        else passed++;
        launch(7'h41, 8'd2, 11'h020);
        total++;
        if ({busy, instr_valid, done} !== 3'b100) $display("FAIL b2b_restart: got %b want 100", {busy, instr_valid, done});
        else passed++;
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_w = {1'b1, rom_word(7'(7'h41 + k)), 11'(11'h020 + k)};
            total++;
            if ({instr_valid, micro_instr_out, data_address_out} !== exp_w)
                $display("FAIL b2b_word[%0d]: got %h want %h", k, {instr_valid, micro_instr_out, data_address_out}, exp_w);
            else passed++;
        end
        tick();
        total++;
        if ({done, busy, instr_valid} !== 3'b100) $display("FAIL b2b_done2: got %b want 100", {done, busy, instr_valid});
        else passed++;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = 7'h0;
        count      = 8'd0;
        data_base  = 11'h0;
        stall      = 1'b0;
        #12;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_count();
        test_ignored_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: run did not end, got %0d/%0d passed", passed, total);
        $fatal(1);
    end

endmodule
